// File: rtl/div_reconstruct.sv
// Reconstructs dividend = quotient*divisor + remainder using a sequential
// radix-2 Booth multiplier followed by a single remainder-add cycle.
module div_reconstruct #(
  parameter int n = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] quotient,
  input  logic [n-1:0] divisor,
  input  logic [n-1:0] remainder,
  output logic [n-1:0] dividend,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

  localparam int unsigned CW = $clog2(n + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [n:0]     a;      // upper half kept one bit wide so -d of the most negative divisor cannot wrap
  logic [n-1:0]   qr;     // multiplier, shifted out as product low bits arrive
  logic           qm1;
  logic [n-1:0]   dr;
  logic [n-1:0]   rr;

  logic [n:0]     dx;
  logic [n:0]     a_nx;
  logic [2*n:0]   sum;
  logic           ovf;

  always_comb begin
    dx   = {dr[n-1], dr};
    a_nx = a;
    unique case ({qr[0], qm1})
      2'b01:   a_nx = a + dx;
      2'b10:   a_nx = a - dx;
      default: a_nx = a;
    endcase
    sum = {a, qr} + {{(n+1){rr[n-1]}}, rr};
    ovf = !((&sum[2*n:n-1]) || (~|sum[2*n:n-1]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a        <= '0;
      qr       <= '0;
      qm1      <= 1'b0;
      dr       <= '0;
      rr       <= '0;
      dividend <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            qr    <= quotient;
            dr    <= divisor;
            rr    <= remainder;
            a     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // arithmetic shift right of {a_nx, qr, qm1}
          {a, qr, qm1} <= {a_nx[n], a_nx, qr};
          cnt          <= cnt + CW'(1);
          if (cnt == CW'(n - 1)) state <= ADD;
        end
        ADD: begin
          dividend <= sum[n-1:0];
          overflow <= ovf;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_reconstruct.sv
// Self-checking bench for div_reconstruct: directed corner cases plus random
// operands against an exact wide-integer model of q*d + r.
module tb_div_reconstruct;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] quotient, divisor, remainder;
  logic [N-1:0] dividend;
  logic         overflow, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_reconstruct #(.n(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .dividend  (dividend),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact reference: wide signed arithmetic, then range test and truncation.
  task automatic model(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r,
                       output logic [N-1:0] dv, output logic ov);
    logic signed [129:0] qs, ds, rs, s, lim;
    qs = $signed(q);
    ds = $signed(d);
    rs = $signed(r);
    s  = qs * ds + rs;
    lim = '0;
    lim[N-1] = 1'b1;
    ov = (s >= lim) || (s < -lim);
    dv = s[N-1:0];
  endtask

  task automatic launch(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r);
    @(negedge clk);
    quotient  = q;
    divisor   = d;
    remainder = r;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 300);
  endtask

  task automatic run_check(input string tag, input logic [N-1:0] q,
                           input logic [N-1:0] d, input logic [N-1:0] r);
    int lat;
    logic [N-1:0] edv;
    logic eov;
    model(q, d, r, edv, eov);
    launch(q, d, r);
    wait_done(0, lat);
    check({tag, "_lat"}, 64'(lat), 64'(N + 1));
    check({tag, "_div"}, dividend, edv);
    check({tag, "_ovf"}, 64'(overflow), 64'(eov));
    @(posedge clk);
    #1;
    check({tag, "_idle"}, 64'({busy, done}), 64'(0));
  endtask

  initial begin
    logic [N-1:0] q, d, r, minv, edv;
    logic eov;
    int lat, extra, runlen, nres;
    logic [31:0] s0, s1, s2;

    reset = 1'b0;
    start = 1'b0;
    quotient = '0; divisor = '0; remainder = '0;
    #1;
    check("rst_div",  dividend, 64'(0));
    check("rst_ovf",  64'(overflow), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_stay", 64'({busy, done}), 64'(0));

    run_check("basic", 64'd3, 64'd3, 64'd2);
    run_check("mix1", -64'sd1, -64'sd99,  64'sd1);
    run_check("mix2", -64'sd1,  64'sd99, -64'sd1);
    run_check("mix3",  64'sd1, -64'sd99, -64'sd1);
    run_check("mix4", -64'sd3,  64'sd3,  -64'sd2);
    run_check("mix5",  64'sd3, -64'sd3,  -64'sd2);

    minv = '0;
    minv[N-1] = 1'b1;
    run_check("bnd1", minv, 64'd1, 64'd0);
    run_check("bnd2", minv, -64'sd1, 64'd0);
    run_check("bnd3", 64'h4000_0000_0000_0000, 64'd4, 64'd0);
    run_check("bnd4", minv, minv, minv);

    for (int i = 0; i < 24; i++) begin
      q = {$urandom, $urandom};
      d = {$urandom, $urandom};
      r = {$urandom, $urandom};
      if (i % 2 == 1) begin
        s0 = $urandom; s1 = $urandom; s2 = $urandom;
        q = {{48{s0[15]}}, s0[15:0]};
        d = {{48{s1[15]}}, s1[15:0]};
        r = {{48{s2[15]}}, s2[15:0]};
      end
      run_check("rand", q, d, r);
    end

    // second start while busy must be dropped
    model(64'd7, 64'd9, 64'd5, edv, eov);
    launch(64'd7, 64'd9, 64'd5);
    lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    start = 1'b1; quotient = 64'd111; divisor = 64'd222; remainder = 64'd333;
    @(posedge clk); #1; lat++;
    start = 1'b0; quotient = 64'd55; divisor = 64'd66; remainder = 64'd77;
    wait_done(lat, lat);
    check("bsy_lat", 64'(lat), 64'(N + 1));
    check("bsy_div", dividend, edv);
    extra = 0;
    repeat (N + 10) begin @(posedge clk); #1; if (done) extra++; end
    check("bsy_single", 64'(extra), 64'(0));
    check("bsy_idle", 64'(busy), 64'(0));

    // reset in the middle of RUN
    launch(64'd123, 64'd456, 64'd7);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("mid_div",  dividend, 64'(0));
    check("mid_ovf",  64'(overflow), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_done", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (N + 10) begin @(posedge clk); #1; if (done) extra++; end
    check("mid_nodone", 64'(extra), 64'(0));
    run_check("mid_after", 64'd4, 64'd3, 64'd0);

    // start held high; operands scrambled while busy
    @(negedge clk);
    quotient = 64'd3; divisor = 64'd5; remainder = 64'd0;
    start = 1'b1;
    runlen = 0;
    nres = 0;
    for (int e = 0; e < 4 * (N + 3) && nres < 3; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        check("b2b_div", dividend, 64'd15);
        check("b2b_ovf", 64'(overflow), 64'(0));
        nres++;
      end
      if (busy) runlen++;
      else if (runlen != 0) begin
        check("b2b_busy", 64'(runlen), 64'(N + 2));
        runlen = 0;
      end
      @(negedge clk);
      if (busy) begin
        quotient = {$urandom, $urandom};
        divisor = {$urandom, $urandom};
        remainder = {$urandom, $urandom};
      end else begin
        quotient = 64'd3; divisor = 64'd5; remainder = 64'd0;
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(nres), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
